serial_word_loader: RTL and testbench

Upstream feeder for the flip-flop register bank. It deserializes a framed serial bit stream (start bit, WIDTH data bits LSB-first, optional even-parity bit, stop bit) into a parallel word. It presents that word on the bank's D inputs together with an active-low one-cycle load strobe wired straight to the bank's active-low enable. It also flags framing and parity errors.

---
 rtl/serial_word_loader_pkg.sv | 17 +
 rtl/serial_word_loader_if.sv | 21 ++
 rtl/serial_word_loader_word_shifter.sv | 34 +++
 rtl/serial_word_loader.sv | 111 +++++++++++
 tb/tb_serial_word_loader.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader: FSM state encoding and a
// helper that sizes the data-bit counter.
package serial_word_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    // Counter must index WIDTH-1 without wrapping; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_word_loader_if.sv
// Serial input / parallel bank-side output bundle of the serial word loader.
interface serial_word_loader_if #(
    parameter int WIDTH = 8
);
    logic             sIn;
    logic             sValid;
    logic [WIDTH-1:0] word;
    logic             loadN;
    logic             busy;
    logic             frameErr;

    modport master (
        output sIn, sValid,
        input  word, loadN, busy, frameErr
    );

    modport slave (
        input  sIn, sValid,
        output word, loadN, busy, frameErr
    );
endinterface

// File: rtl/serial_word_loader_word_shifter.sv
// Data shift register for the loader: bits enter at the MSB so the first
// (LSB-first) bit ends up in bit 0 after WIDTH shifts; tracks running XOR.
module word_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             aReset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] data,
    output logic             parity
);

    logic [WIDTH-1:0] data_reg;
    logic             parity_reg;

    always_ff @(posedge clk or negedge aReset) begin
        if (!aReset) begin
            data_reg   <= '0;
            parity_reg <= 1'b0;
        end else if (clear) begin
            data_reg   <= '0;
            parity_reg <= 1'b0;
        end else if (shift_en) begin
            data_reg   <= {din, data_reg[WIDTH-1:1]};
            parity_reg <= parity_reg ^ din;
        end
    end

    assign data   = data_reg;
    assign parity = parity_reg;

endmodule

// File: rtl/serial_word_loader.sv
// Deserializes start/data/[parity]/stop frames into a word for the register
// bank and issues a one-cycle active-low load strobe or an error pulse.
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                  clk,
    input  logic                  aReset,
    input  logic                  reset,
    serial_word_loader_if.slave   bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] word_reg;
    logic             load_n_reg;
    logic             busy_reg;
    logic             frame_err_reg;
    logic             par_err_reg;

    logic             start_sample;
    logic             shift_en;
    logic             shift_clear;
    logic [WIDTH-1:0] shift_data;
    logic             shift_parity;

    assign start_sample = bus.sValid && !bus.sIn && (state_reg == IDLE);
    assign shift_en     = bus.sValid && (state_reg == DATA);
    assign shift_clear  = !reset || start_sample;

    word_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk      (clk),
        .aReset   (aReset),
        .clear    (shift_clear),
        .shift_en (shift_en),
        .din      (bus.sIn),
        .data     (shift_data),
        .parity   (shift_parity)
    );

    always_ff @(posedge clk or negedge aReset) begin
        if (!aReset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            word_reg      <= '0;
            load_n_reg    <= 1'b1;
            busy_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            par_err_reg   <= 1'b0;
        end else if (!reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            word_reg      <= '0;
            load_n_reg    <= 1'b1;
            busy_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            par_err_reg   <= 1'b0;
        end else begin
            // Strobes default back to idle every edge, stalled or not.
            load_n_reg    <= 1'b1;
            frame_err_reg <= 1'b0;
            if (bus.sValid) begin
                case (state_reg)
                    IDLE: begin
                        if (!bus.sIn) begin
                            state_reg   <= DATA;
                            count_reg   <= '0;
                            busy_reg    <= 1'b1;
                            par_err_reg <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (count_reg == LAST) begin
                            state_reg <= PARITY_EN ? PAR : STOP;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                    PAR: begin
                        par_err_reg <= shift_parity ^ bus.sIn;
                        state_reg   <= STOP;
                    end
                    STOP: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        if (bus.sIn && !par_err_reg) begin
                            word_reg   <= shift_data;
                            load_n_reg <= 1'b0;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.word     = word_reg;
    assign bus.loadN    = load_n_reg;
    assign bus.busy     = busy_reg;
    assign bus.frameErr = frame_err_reg;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench: table of frames on a no-parity instance, hand sequences for
// back-to-back, resets and the even-parity instance.
module tb_serial_word_loader;

    logic clk;
    logic aReset;
    logic reset;

    serial_word_loader_if #(.WIDTH(8)) if0 ();
    serial_word_loader_if #(.WIDTH(8)) if1 ();

    serial_word_loader #(.WIDTH(8), .PARITY_EN(1'b0)) dut0 (
        .clk    (clk),
        .aReset (aReset),
        .reset  (reset),
        .bus    (if0)
    );

    serial_word_loader #(.WIDTH(8), .PARITY_EN(1'b1)) dut1 (
        .clk    (clk),
        .aReset (aReset),
        .reset  (reset),
        .bus    (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int f_edges, f_busy, f_early;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         stall_at;
        int         stall_len;
        logic       exp_load;
        logic [7:0] exp_word;
        int         exp_edges;
        int         exp_busy;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_loadn(input int w);
        return (w == 0) ? if0.loadN : if1.loadN;
    endfunction
    function automatic logic get_err(input int w);
        return (w == 0) ? if0.frameErr : if1.frameErr;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 0) ? if0.busy : if1.busy;
    endfunction
    function automatic logic [7:0] get_word(input int w);
        return (w == 0) ? if0.word : if1.word;
    endfunction

    task automatic set_in(input int w, input logic b, input logic v);
        if (w == 0) begin
            if0.sIn = b; if0.sValid = v;
        end else begin
            if1.sIn = b; if1.sValid = v;
        end
    endtask

    task automatic drive(input int w, input logic b, input logic v);
        set_in(w, b, v);
        @(posedge clk);
        #1;
    endtask

    // Bookkeeping after every edge inside a frame (before the stop sample).
    task automatic acct(input int w);
        f_edges++;
        if (get_busy(w)) f_busy++;
        if (!get_loadn(w) || get_err(w)) f_early++;
    endtask

    task automatic frame(input int w, input logic [7:0] d, input int par, input logic stop,
                         input int stall_at, input int stall_len);
        f_edges = 0; f_busy = 0; f_early = 0;
        drive(w, 1'b0, 1'b1);
        acct(w);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    drive(w, 1'b1, 1'b0);
                    acct(w);
                end
            end
            drive(w, d[i], 1'b1);
            acct(w);
        end
        if (par >= 0) begin
            drive(w, par[0], 1'b1);
            acct(w);
        end
        drive(w, stop, 1'b1);
        f_edges++;
        set_in(w, 1'b1, 1'b0);
    endtask

    // Checks the edge after the stop sample; optionally one idle edge more.
    task automatic post(input int w, input string name, input logic exp_load,
                        input logic [7:0] exp_word, input bit idle_after);
        chk({name, "_loadN"},    get_loadn(w), !exp_load);
        chk({name, "_frameErr"}, get_err(w),   !exp_load);
        chk({name, "_word"},     get_word(w),  exp_word);
        chk({name, "_busy"},     get_busy(w),  1'b0);
        if (idle_after) begin
            drive(w, 1'b1, 1'b0);
            chk({name, "_loadN_1cyc"},    get_loadn(w), 1'b1);
            chk({name, "_frameErr_1cyc"}, get_err(w),   1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, -1, 0, 1'b1, 8'hA5, 10,  9};
        vecs[1] = '{8'hA5, 1'b0, -1, 0, 1'b0, 8'hA5, 10,  9};
        vecs[2] = '{8'h3C, 1'b1,  5, 3, 1'b1, 8'h3C, 13, 12};
        vecs[3] = '{8'hC3, 1'b1,  0, 1, 1'b1, 8'hC3, 11, 10};

        aReset = 1'b0;
        reset  = 1'b1;
        set_in(0, 1'b1, 1'b0);
        set_in(1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("rst%0d_word", w),     get_word(w),  8'h00);
            chk($sformatf("rst%0d_loadN", w),    get_loadn(w), 1'b1);
            chk($sformatf("rst%0d_busy", w),     get_busy(w),  1'b0);
            chk($sformatf("rst%0d_frameErr", w), get_err(w),   1'b0);
        end
        aReset = 1'b1;
        drive(0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            frame(0, vecs[i].data, -1, vecs[i].stop, vecs[i].stall_at, vecs[i].stall_len);
            chk($sformatf("v%0d_edges", i), f_edges, vecs[i].exp_edges);
            chk($sformatf("v%0d_busy_cycles", i), f_busy, vecs[i].exp_busy);
            chk($sformatf("v%0d_early_strobe", i), f_early, 0);
            post(0, $sformatf("v%0d", i), vecs[i].exp_load, vecs[i].exp_word, 1'b1);
            $display("vector %0d: data=0x%02h stop=%0b word=0x%02h", i, vecs[i].data, vecs[i].stop, get_word(0));
        end

        // Back-to-back frames: second start immediately after first stop.
        frame(0, 8'h01, -1, 1'b1, -1, 0);
        post(0, "b2b_first", 1'b1, 8'h01, 1'b0);
        frame(0, 8'h80, -1, 1'b1, -1, 0);
        chk("b2b_second_early", f_early, 0);
        post(0, "b2b_second", 1'b1, 8'h80, 1'b1);
        $display("back-to-back: word=0x%02h", get_word(0));

        // Asynchronous reset mid-frame: outputs clear without a clock edge.
        drive(0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 1'b1);
        chk("ar_busy_before", get_busy(0), 1'b1);
        set_in(0, 1'b1, 1'b0);
        #1 aReset = 1'b0;
        #1;
        chk("ar_word_now",  get_word(0),  8'h00);
        chk("ar_loadN_now", get_loadn(0), 1'b1);
        chk("ar_busy_now",  get_busy(0),  1'b0);
        #3 aReset = 1'b1;
        drive(0, 1'b1, 1'b0);
        chk("ar_frameErr_after", get_err(0), 1'b0);
        frame(0, 8'h12, -1, 1'b1, -1, 0);
        chk("ar_next_early", f_early, 0);
        post(0, "ar_next", 1'b1, 8'h12, 1'b1);
        $display("async reset: reloaded word=0x%02h", get_word(0));

        // Synchronous reset mid-frame: takes effect only at the edge.
        drive(0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 1'b1);
        reset = 1'b0;
        set_in(0, 1'b1, 1'b1);
        #1;
        chk("sr_busy_before_edge", get_busy(0), 1'b1);
        drive(0, 1'b1, 1'b1);
        reset = 1'b1;
        chk("sr_word",     get_word(0),  8'h00);
        chk("sr_loadN",    get_loadn(0), 1'b1);
        chk("sr_busy",     get_busy(0),  1'b0);
        chk("sr_frameErr", get_err(0),   1'b0);
        drive(0, 1'b1, 1'b0);
        frame(0, 8'h12, -1, 1'b1, -1, 0);
        chk("sr_next_early", f_early, 0);
        post(0, "sr_next", 1'b1, 8'h12, 1'b1);
        $display("sync reset: reloaded word=0x%02h", get_word(0));

        // Even-parity instance: 0x07 has three ones, so the parity bit must be 1.
        frame(1, 8'h07, 1, 1'b1, -1, 0);
        chk("par_ok_edges", f_edges, 11);
        chk("par_ok_busy_cycles", f_busy, 10);
        chk("par_ok_early", f_early, 0);
        post(1, "par_ok", 1'b1, 8'h07, 1'b1);
        $display("parity good: word=0x%02h", get_word(1));
        frame(1, 8'h07, 0, 1'b1, -1, 0);
        chk("par_bad_early", f_early, 0);
        post(1, "par_bad", 1'b0, 8'h07, 1'b1);
        $display("parity bad: word=0x%02h", get_word(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
